// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with full-scan debounce, emitting one lock-encoded
// key_code strobe per accepted press (1111 idle, 1110 set, 1101 cancel, digits).
module keypad_scan_encoder #(
    parameter int SCAN_DIV       = 10_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]       CODE_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_kind_e;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_e;

    // Key index is {row, col}; returns {has_code, code}.
    function automatic logic [4:0] key_lookup(input logic [3:0] key);
        logic [4:0] r;
        case (key)
            4'h0:    r = 5'b1_0001;  // '1'
            4'h1:    r = 5'b1_0010;  // '2'
            4'h2:    r = 5'b1_0011;  // '3'
            4'h4:    r = 5'b1_0100;  // '4'
            4'h5:    r = 5'b1_0101;  // '5'
            4'h6:    r = 5'b1_0110;  // '6'
            4'h8:    r = 5'b1_0111;  // '7'
            4'h9:    r = 5'b1_1000;  // '8'
            4'hA:    r = 5'b1_1001;  // '9'
            4'hC:    r = 5'b1_1101;  // '*' cancel
            4'hD:    r = 5'b1_0000;  // '0'
            4'hE:    r = 5'b1_1110;  // '#' set
            default: r = 5'b0_1111;  // A..D carry no code
        endcase
        return r;
    endfunction

    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    res_kind_e        acc_kind_q, acc_kind_d;
    logic [3:0]       acc_key_q, acc_key_d;
    res_kind_e        cand_kind_q, cand_kind_d;
    logic [3:0]       cand_key_q, cand_key_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    state_e           state_q, state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;

    logic [3:0]       row_low;
    logic             sample;
    logic             finalize;
    logic [2:0]       low_cnt;
    logic [1:0]       low_row;
    res_kind_e        base_kind;
    res_kind_e        merged_kind;
    logic [3:0]       merged_key;
    logic [4:0]       lookup;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_low[gi] = ~row_sync_q[gi];
        end
    endgenerate

    assign row_meta_d = row_n;
    assign row_sync_d = row_meta_q;

    assign sample   = (div_q == DIV_LAST);
    assign finalize = sample && (col_idx_q == 2'd3);

    always_comb begin
        div_d     = sample ? '0 : div_q + DIV_W'(1);
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    end

    // Fold this column's sample into the running scan result; column 0 starts fresh.
    always_comb begin
        low_cnt = 3'd0;
        low_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row_low[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_row = 2'(i);
            end
        end

        base_kind   = (col_idx_q == 2'd0) ? RES_NONE : acc_kind_q;
        merged_kind = base_kind;
        merged_key  = (col_idx_q == 2'd0) ? 4'd0 : acc_key_q;

        case (base_kind)
            RES_NONE: begin
                if (low_cnt == 3'd1) begin
                    merged_kind = RES_KEY;
                    merged_key  = {low_row, col_idx_q};
                end else if (low_cnt != 3'd0) begin
                    merged_kind = RES_MULTI;
                end
            end
            RES_KEY: begin
                if (low_cnt != 3'd0) begin
                    merged_kind = RES_MULTI;
                end
            end
            default: merged_kind = RES_MULTI;
        endcase

        acc_kind_d = sample ? merged_kind : acc_kind_q;
        acc_key_d  = sample ? merged_key  : acc_key_q;
    end

    always_comb begin
        cand_kind_d  = cand_kind_q;
        cand_key_d   = cand_key_q;
        stable_cnt_d = stable_cnt_q;
        if (finalize) begin
            if ((merged_kind == cand_kind_q) &&
                ((merged_kind != RES_KEY) || (merged_key == cand_key_q))) begin
                if (stable_cnt_q != CNT_MAX) begin
                    stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end
            end else begin
                cand_kind_d  = merged_kind;
                cand_key_d   = merged_key;
                stable_cnt_d = CNT_W'(1);
            end
        end
    end

    assign lookup = key_lookup(cand_key_d);

    // Decisions use the post-finalization candidate so the strobe lands one cycle later.
    always_comb begin
        state_d     = state_q;
        key_code_d  = CODE_IDLE;
        key_valid_d = 1'b0;
        if (finalize) begin
            case (state_q)
                ST_RELEASED: begin
                    if ((cand_kind_d == RES_KEY) && (stable_cnt_d == CNT_MAX)) begin
                        state_d = ST_PRESSED;
                        if (lookup[4]) begin
                            key_valid_d = 1'b1;
                            key_code_d  = lookup[3:0];
                        end
                    end
                end
                ST_PRESSED: begin
                    if ((cand_kind_d == RES_NONE) && (stable_cnt_d == CNT_MAX)) begin
                        state_d = ST_RELEASED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q   <= 4'b1111;
            row_sync_q   <= 4'b1111;
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            acc_kind_q   <= RES_NONE;
            acc_key_q    <= 4'd0;
            cand_kind_q  <= RES_NONE;
            cand_key_q   <= 4'd0;
            stable_cnt_q <= '0;
            state_q      <= ST_RELEASED;
            key_code_q   <= CODE_IDLE;
            key_valid_q  <= 1'b0;
        end else begin
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            div_q        <= div_d;
            col_idx_q    <= col_idx_d;
            acc_kind_q   <= acc_kind_d;
            acc_key_q    <= acc_key_d;
            cand_kind_q  <= cand_kind_d;
            cand_key_q   <= cand_key_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == ST_PRESSED);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: a keypad matrix model drives row_n from col_n,
// expected strobes go into a queue that a negedge monitor pops and compares.
module tb_keypad_scan_encoder;

    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] sb_q[$];

    always #5 clk = ~clk;

    keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed key at (r,c) shorts row r low while column c is driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_drained(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 4 * SCAN) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, sb_q.size(), 0);
    endtask

    task automatic expect_released(input string name);
        int t = 0;
        while (key_held !== 1'b0 && t < 3 * SCAN + 4) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, {31'd0, key_held}, 0);
    endtask

    // Returns just after the posedge that wraps the scan back to column 0.
    task automatic align_scan();
        logic [3:0] prev;
        int found = 0;
        prev = col_n;
        for (int t = 0; t < 2 * SCAN && found == 0; t++) begin
            @(posedge clk);
            #1;
            if (col_n == 4'b1110 && prev == 4'b0111) found = 1;
            prev = col_n;
        end
        check("align_scan", found, 1);
    endtask

    // Monitor: every strobe must match the oldest expected code.
    initial begin
        logic [3:0] exp_code;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("col_onehot", $countones(~col_n), 1);
                if (key_valid) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: actual code=%b required no strobe", key_code);
                    end else begin
                        exp_code = sb_q.pop_front();
                        $display("strobe: key_code=%b expected=%b key_held=%b", key_code, exp_code, key_held);
                        check("strobe_code", {28'd0, key_code}, {28'd0, exp_code});
                        check("held_at_strobe", {31'd0, key_held}, 1);
                    end
                end else begin
                    check("idle_code", {28'd0, key_code}, 32'hF);
                end
            end
        end
    end

    typedef struct {
        int         bit_idx;
        logic [3:0] code;
    } press_t;

    initial begin
        logic [3:0] exp_col;
        logic [3:0] one;
        press_t     t3 [3];
        t3[0] = '{13, 4'b0000};
        t3[1] = '{12, 4'b1101};
        t3[2] = '{14, 4'b1110};
        one = 4'b0001;

        // Reset values, then column sequence.
        rst = 1'b1;
        run(2);
        @(negedge clk);
        check("rst_col_n", {28'd0, col_n}, 32'hE);
        check("rst_key_code", {28'd0, key_code}, 32'hF);
        check("rst_key_valid", {31'd0, key_valid}, 0);
        check("rst_key_held", {31'd0, key_held}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_col = ~(one << ((k / SD) % 4));
            check("t1_col_seq", {28'd0, col_n}, {28'd0, exp_col});
            check("t1_code_idle", {28'd0, key_code}, 32'hF);
            check("t1_valid_low", {31'd0, key_valid}, 0);
        end
        run(1);

        // '5' clean press for 6 scans.
        sb_q.push_back(4'b0101);
        keys = 16'(1 << 5);
        run(6 * SCAN);
        expect_drained("t2_strobe_5");
        check("t2_held", {31'd0, key_held}, 1);
        keys = '0;
        expect_released("t2_release");

        // '0', '*', '#' in turn.
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(t3[i].code);
            keys = 16'(1 << t3[i].bit_idx);
            run(5 * SCAN);
            expect_drained("t3_strobe");
            keys = '0;
            expect_released("t3_release");
        end

        // '8' bouncing every 3 cycles for two scans, aligned so no scan sees it pressed.
        align_scan();
        for (int c = 0; c < 2 * SCAN; c++) begin
            keys = ((c / 3) % 2 == 0) ? 16'(1 << 9) : 16'd0;
            run(1);
        end
        sb_q.push_back(4'b1000);
        keys = 16'(1 << 9);
        run(5 * SCAN);
        expect_drained("t4_strobe_8");
        keys = '0;
        expect_released("t4_release");

        // '1'+'2' together: ignored.
        keys = 16'(1 << 0) | 16'(1 << 1);
        run(5 * SCAN);
        check("t5_multi_held", {31'd0, key_held}, 0);
        keys = '0;
        run(3 * SCAN);

        // 'A': held, no strobe.
        keys = 16'(1 << 3);
        run(5 * SCAN);
        check("t5_a_held", {31'd0, key_held}, 1);
        keys = '0;
        expect_released("t5_a_release");

        // '3' then add '6' while held.
        sb_q.push_back(4'b0011);
        keys = 16'(1 << 2);
        run(4 * SCAN);
        keys = keys | 16'(1 << 6);
        run(4 * SCAN);
        expect_drained("t5_strobe_3");
        check("t5_36_held", {31'd0, key_held}, 1);
        keys = '0;
        expect_released("t5_36_release");

        // Reset while '7' is held, then re-acceptance.
        sb_q.push_back(4'b0111);
        keys = 16'(1 << 8);
        run(5 * SCAN);
        expect_drained("t6_strobe_7");
        check("t6_held_before", {31'd0, key_held}, 1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_col_n", {28'd0, col_n}, 32'hE);
        check("t6_rst_key_code", {28'd0, key_code}, 32'hF);
        check("t6_rst_key_valid", {31'd0, key_valid}, 0);
        check("t6_rst_key_held", {31'd0, key_held}, 0);
        sb_q.push_back(4'b0111);
        run(5 * SCAN);
        expect_drained("t6_restrobe_7");
        check("t6_held_after", {31'd0, key_held}, 1);
        keys = '0;
        expect_released("t6_release");
        run(2 * SCAN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
